// File: rtl/framebuffer_addrgen.sv
// Framebuffer read-address generator: raster scan beats interleaved with random-access
// requests, mapped onto a bank/block/word/pixel BRAM organisation behind one output register.
module framebuffer_addrgen #(
    parameter int WIDTH           = 1024,
    parameter int HEIGHT          = 512,
    parameter int BPP             = 1,
    parameter int WORD_WIDTH      = 16,
    parameter int BRAM_BITS       = 16384,
    parameter int NUM_BANKS       = 4,
    parameter int BLOCKS_PER_BANK = 8,
    localparam int PPW   = WORD_WIDTH / BPP,
    localparam int WPL   = WIDTH / PPW,
    localparam int LPB   = BRAM_BITS / (WIDTH * BPP),
    localparam int A_W   = $clog2(BRAM_BITS / WORD_WIDTH),
    localparam int X_W   = $clog2(WIDTH) + 1,
    localparam int Y_W   = $clog2(HEIGHT) + 1,
    localparam int BLK_W = (BLOCKS_PER_BANK > 1) ? $clog2(BLOCKS_PER_BANK) : 1,
    localparam int PIX_W = (PPW > 1) ? $clog2(PPW) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 scan_en,
    input  logic                 scan_start,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [X_W-1:0]       req_x,
    input  logic [Y_W-1:0]       req_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_BANKS-1:0] out_bank,
    output logic [BLK_W-1:0]     out_block,
    output logic [A_W-1:0]       out_addr,
    output logic [PIX_W-1:0]     out_pix,
    output logic                 out_src,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 out_err,
    output logic                 frame_done
);

    localparam int SX_W = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int SY_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    if ((NUM_BANKS * BLOCKS_PER_BANK * LPB != HEIGHT) || !is_pow2(WIDTH) || !is_pow2(HEIGHT) ||
        !is_pow2(BPP) || (BPP > 8) || !is_pow2(WORD_WIDTH) || !is_pow2(BRAM_BITS) ||
        !is_pow2(NUM_BANKS) || !is_pow2(BLOCKS_PER_BANK) || !is_pow2(PPW) || !is_pow2(WPL) ||
        !is_pow2(LPB)) begin : g_bad_geometry
        $error("framebuffer_addrgen: inconsistent frame/BRAM geometry parameters");
    end

    logic                 out_valid_q, out_valid_d;
    logic [NUM_BANKS-1:0] out_bank_q, out_bank_d;
    logic [BLK_W-1:0]     out_block_q, out_block_d;
    logic [A_W-1:0]       out_addr_q, out_addr_d;
    logic [PIX_W-1:0]     out_pix_q, out_pix_d;
    logic                 out_src_q, out_src_d;
    logic                 out_sof_q, out_sof_d;
    logic                 out_eol_q, out_eol_d;
    logic                 out_err_q, out_err_d;
    logic                 frame_done_q, frame_done_d;
    logic [SX_W-1:0]      sx_q, sx_d;
    logic [SY_W-1:0]      sy_q, sy_d;

    logic        load, issue_req, issue_scan, issue, req_err, last_x, last_y;
    logic [31:0] map_x, map_y, bank_idx;

    always_comb begin
        load       = !out_valid_q || out_ready;
        issue_req  = load && req_valid;
        issue_scan = load && scan_en && !req_valid && !scan_start;
        issue      = issue_req || issue_scan;
        last_x     = (sx_q == SX_W'(WPL - 1));
        last_y     = (sy_q == SY_W'(HEIGHT - 1));

        // Request coordinates take the mapping path whenever present, since they win arbitration.
        if (req_valid) begin
            map_x = 32'(req_x);
            map_y = 32'(req_y);
        end else begin
            map_x = 32'(sx_q) * 32'(PPW);
            map_y = 32'(sy_q);
        end
        req_err  = req_valid && ((map_x >= 32'(WIDTH)) || (map_y >= 32'(HEIGHT)));
        bank_idx = (map_y / 32'(LPB * BLOCKS_PER_BANK)) % 32'(NUM_BANKS);

        out_valid_d  = load ? issue : out_valid_q;
        out_bank_d   = out_bank_q;
        out_block_d  = out_block_q;
        out_addr_d   = out_addr_q;
        out_pix_d    = out_pix_q;
        out_src_d    = out_src_q;
        out_sof_d    = out_sof_q;
        out_eol_d    = out_eol_q;
        out_err_d    = out_err_q;
        frame_done_d = issue_scan && last_x && last_y;
        sx_d         = sx_q;
        sy_d         = sy_q;

        if (issue) begin
            out_src_d = issue_req;
            out_sof_d = issue_scan && (sx_q == '0) && (sy_q == '0);
            out_eol_d = issue_scan && last_x;
            out_err_d = req_err;
            if (req_err) begin
                out_bank_d  = '0;
                out_block_d = '0;
                out_addr_d  = '0;
                out_pix_d   = '0;
            end else begin
                out_bank_d  = NUM_BANKS'(1) << bank_idx;
                out_block_d = BLK_W'((map_y / 32'(LPB)) % 32'(BLOCKS_PER_BANK));
                out_addr_d  = A_W'((map_y % 32'(LPB)) * 32'(WPL) + map_x / 32'(PPW));
                out_pix_d   = PIX_W'(map_x % 32'(PPW));
            end
        end

        // A restart overrides the advance of any beat issued in the same cycle.
        if (scan_start) begin
            sx_d = '0;
            sy_d = '0;
        end else if (issue_scan) begin
            if (last_x) begin
                sx_d = '0;
                sy_d = last_y ? '0 : sy_q + SY_W'(1);
            end else begin
                sx_d = sx_q + SX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_bank_q   <= '0;
            out_block_q  <= '0;
            out_addr_q   <= '0;
            out_pix_q    <= '0;
            out_src_q    <= 1'b0;
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            out_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
            sx_q         <= '0;
            sy_q         <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_bank_q   <= out_bank_d;
            out_block_q  <= out_block_d;
            out_addr_q   <= out_addr_d;
            out_pix_q    <= out_pix_d;
            out_src_q    <= out_src_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
            out_err_q    <= out_err_d;
            frame_done_q <= frame_done_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
        end
    end

    assign req_ready  = load;
    assign out_valid  = out_valid_q;
    assign out_bank   = out_bank_q;
    assign out_block  = out_block_q;
    assign out_addr   = out_addr_q;
    assign out_pix    = out_pix_q;
    assign out_src    = out_src_q;
    assign out_sof    = out_sof_q;
    assign out_eol    = out_eol_q;
    assign out_err    = out_err_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_framebuffer_addrgen.sv
// Bench for framebuffer_addrgen at default geometry: directed steps plus randomized traffic
// checked against a coordinate-level reference model of scan position and output register.
module tb_framebuffer_addrgen;

    localparam int WIDTH  = 1024;
    localparam int HEIGHT = 512;
    localparam int PPW    = 16;
    localparam int WPL    = WIDTH / PPW;
    localparam int LPB    = 16;
    localparam int BLOCKS = 8;
    localparam int BANKS  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scan_en, scan_start, req_valid, req_ready, out_valid, out_ready;
    logic [10:0] req_x;
    logic [9:0]  req_y;
    logic [3:0]  out_bank;
    logic [2:0]  out_block;
    logic [9:0]  out_addr;
    logic [3:0]  out_pix;
    logic        out_src, out_sof, out_eol, out_err, frame_done;

    framebuffer_addrgen dut (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .scan_start(scan_start),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_bank(out_bank),
        .out_block(out_block), .out_addr(out_addr), .out_pix(out_pix), .out_src(out_src),
        .out_sof(out_sof), .out_eol(out_eol), .out_err(out_err), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bank, block, addr, pix, src, sof, eol, err;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    bit    m_valid, m_fd;
    int    m_sx, m_sy;
    beat_t m_beat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pixel (x,y) lives in bank y/(lines per bank), block within that bank, line within block.
    function automatic beat_t map_pixel(input int x, input int y, input int src);
        beat_t b;
        b = '{default: 0};
        b.src = src;
        if (x >= WIDTH || y >= HEIGHT) begin
            b.err = 1;
        end else begin
            b.bank  = 1 << (y / (HEIGHT / BANKS));
            b.block = (y % (HEIGHT / BANKS)) / LPB;
            b.addr  = (y % LPB) * WPL + x / PPW;
            b.pix   = x % PPW;
        end
        return b;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_fd    = 0;
        m_sx    = 0;
        m_sy    = 0;
        m_beat  = '{default: 0};
    endtask

    task automatic model_step();
        bit take;
        take = !m_valid || out_ready;
        m_fd = 0;
        if (take && req_valid) begin
            m_beat  = map_pixel(int'(req_x), int'(req_y), 1);
            m_valid = 1;
        end else if (take && scan_en && !scan_start) begin
            m_beat     = map_pixel(m_sx * PPW, m_sy, 0);
            m_beat.sof = (m_sx == 0 && m_sy == 0);
            m_beat.eol = (m_sx == WPL - 1);
            m_fd       = (m_sx == WPL - 1 && m_sy == HEIGHT - 1);
            m_valid    = 1;
            m_sx++;
            if (m_sx == WPL) begin
                m_sx = 0;
                m_sy = (m_sy + 1) % HEIGHT;
            end
        end else if (take) begin
            m_valid = 0;
        end
        if (scan_start) begin
            m_sx = 0;
            m_sy = 0;
        end
    endtask

    task automatic compare_all();
        check("out_valid", out_valid, m_valid);
        check("frame_done", frame_done, m_fd);
        if (m_valid) begin
            check("out_bank", out_bank, m_beat.bank);
            check("out_block", out_block, m_beat.block);
            check("out_addr", out_addr, m_beat.addr);
            check("out_pix", out_pix, m_beat.pix);
            check("out_src", out_src, m_beat.src);
            check("out_sof", out_sof, m_beat.sof);
            check("out_eol", out_eol, m_beat.eol);
            check("out_err", out_err, m_beat.err);
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        #1;
        check("req_ready", req_ready, (!m_valid || out_ready));
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_fields"}, {out_bank, out_block, out_addr, out_pix,
                                 out_src, out_sof, out_eol, out_err}, 0);
    endtask

    initial begin
        rst_n = 0; scan_en = 0; scan_start = 0; req_valid = 0; out_ready = 0;
        req_x = '0; req_y = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1;

        // Directed request (37,300)
        out_ready = 1; req_valid = 1; req_x = 11'd37; req_y = 10'd300;
        cycle();
        req_valid = 0;
        check("d_bank", out_bank, 4'b0100);
        check("d_block", out_block, 2);
        check("d_addr", out_addr, 770);
        check("d_pix", out_pix, 5);
        check("d_src", out_src, 1);
        check("d_err", out_err, 0);

        // Out-of-range request
        req_valid = 1; req_x = 11'd1024; req_y = 10'd0;
        cycle();
        req_valid = 0;
        check("e_err", out_err, 1);
        check("e_bank", out_bank, 0);
        cycle();
        check("e_drain", out_valid, 0);

        // One full frame of scan beats with no back-pressure
        scan_en = 1;
        for (int i = 0; i < WPL * HEIGHT; i++) begin
            cycle();
            check("f_eol", out_eol, (i % WPL) == WPL - 1);
            if (i == 0) check("f_sof", out_sof, 1);
            if (i == WPL * HEIGHT - 1) begin
                check("f_last_bank", out_bank, 4'b1000);
                check("f_last_block", out_block, 7);
                check("f_last_addr", out_addr, 1023);
                check("f_done", frame_done, 1);
            end
        end
        cycle();
        check("f_done_pulse", frame_done, 0);
        check("f_wrap_sof", out_sof, 1);

        // Requests interleaved into an active scan, then a 5-cycle stall
        repeat (10) cycle();
        for (int i = 0; i < 3; i++) begin
            req_valid = 1;
            req_x = 11'($urandom_range(0, WIDTH - 1));
            req_y = 10'($urandom_range(0, HEIGHT - 1));
            cycle();
            check("i_src", out_src, 1);
        end
        req_valid = 0;
        cycle();
        check("i_resume_src", out_src, 0);
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("s_ready", req_ready, 0);
        end
        out_ready = 1;
        repeat (3) cycle();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            req_valid  = ($urandom_range(0, 4) == 0);
            req_x      = 11'($urandom_range(0, 1100));
            req_y      = 10'($urandom_range(0, 600));
            out_ready  = ($urandom_range(0, 3) != 0);
            scan_en    = ($urandom_range(0, 7) != 0);
            scan_start = ($urandom_range(0, 99) == 0);
            cycle();
        end
        req_valid = 0; scan_start = 0; scan_en = 1; out_ready = 1;

        // Reset in the middle of a scan
        repeat (100) cycle();
        rst_n = 0;
        #1;
        check_all_zero("mid_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_all_zero("mid_reset_held");
        rst_n = 1;
        cycle();
        check("r_first_sof", out_sof, 1);
        check("r_first_addr", out_addr, 0);
        repeat (70) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
